mixcol_addkey_serial: RTL and testbench
=======================================

Name: mixcol_addkey_serial

Overview:
- Sequential AES round back-end that sits directly downstream of the combinational ShiftRows stage.
- Consumes the 128-bit ShiftRows output and a 128-bit round key, then applies MixColumns followed by AddRoundKey, processing COLS_PER_CYCLE columns per clock.
- For the final round (last_round_i=1), MixColumns is bypassed and only AddRoundKey is applied.
- Uses valid/ready handshakes on both sides; the result feeds the next-round state register in the encryption controller.

Parameters:
- COLS_PER_CYCLE, default 1: columns processed per cycle. Legal values are 1, 2, 4; any other value is an elaboration error.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream block valid.
- ready_o  output  1  block can accept input.
- data_i  input  128  ShiftRows output state.
- key_i  input  128  round key, same byte layout as data_i.
- last_round_i  input  1  1 = skip MixColumns (final round).
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- data_o  output  128  round result.

Behaviour:
- Reset is asynchronous and active-low; the design has one clock (clk_i) and one reset (rst_ni).
- Byte layout:
  - data[127:96] is column 0, data[95:64] column 1, data[63:32] column 2, data[31:0] column 3.
  - Within a column, bits [31:24] are row 0 and bits [7:0] are row 3.
- Reset (rst_ni=0, asynchronous): state=IDLE, column counter=0, internal state/key/result registers=0, valid_o=0, data_o=0, ready_o=1 once reset is released.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - On an edge with valid_i=1, capture data_i, key_i and last_round_i into internal registers; col_cnt=0; go to BUSY.
- BUSY:
  - ready_o=0, valid_o=0.
  - Each edge computes columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 and writes them into the result register.
  - col_cnt advances by COLS_PER_CYCLE.
  - After the edge that writes column 3, go to DONE.
  - valid_i and the input buses are ignored in this state; a changing data_i must not affect the result.
- DONE:
  - valid_o=1, data_o = result register, held stable while ready_i=0.
  - On an edge with ready_i=1, go to IDLE.
  - There is no input acceptance in DONE, so there is no combinational ready_i to ready_o path.
- Latency: the acceptance edge is E0; valid_o rises after edge E(4/COLS_PER_CYCLE).
- Throughput: one block per 4/COLS_PER_CYCLE + 2 cycles when ready_i is held at 1.
- MixColumns per column (a0..a3 = rows 0..3), using GF(2^8) with xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Output per column:
  - last_round=0: out = MixColumns(col) ^ key column.
  - last_round=1: out = col ^ key column.
- data_o equals the result register in every state. Its value is don't-care-but-stable outside DONE; it changes only on BUSY edges.
- Reset asserted mid-operation: immediate return to IDLE with valid_o=0 and data_o=0. No partial result ever appears after reset.
- valid_i held high across DONE→IDLE: the new block is accepted on the first IDLE edge, never on the DONE exit edge.

Test Plan:
- Single column, key=0, last=0, data_i column 0 = db135345 (other columns 01010101, c6c6c6c6, d4d4d4d5) -> data_o = 8e4da1bc 01010101 c6c6c6c6 d5d5d7d6.
- FIPS-197 App. B round 1:
  - Stimulus: data_i = d4bf5d30 e0b452ae b84111f1 1e2798e5, key_i = a0fafe17 88542cb1 23a33939 2a6c7605, last=0.
  - Response: data_o = a49c7ff2 689f352b 6b5bea43 026a5049.
  - valid_o rises exactly 4 edges after acceptance (COLS_PER_CYCLE=1) and 1 edge after acceptance (COLS_PER_CYCLE=4).
- Final round: same data_i, key_i=0, last=1 -> data_o = data_i unchanged. With key_i = all ff -> data_o = bitwise inverse of data_i.
- Backpressure: ready_i=0 for 10 cycles in DONE -> valid_o stays 1, data_o stable, ready_o=0. A different data_i/valid_i pulsed during this window is not captured.
- Reset mid-BUSY: drop rst_ni after 2 column edges -> valid_o=0 and data_o=0 immediately (asynchronous). After release, ready_o=1 and a fresh block produces the correct result.
- Back-to-back: valid_i high continuously with ready_i=1 and two vectors presented -> both results emerge in order, with the second accepted only in IDLE, spaced 6 cycles apart (COLS_PER_CYCLE=1).

Source files
------------

// File: rtl/mixcol_addkey_serial.sv
// AES round back-end: MixColumns followed by AddRoundKey, COLS_PER_CYCLE
// columns per clock. Sits after ShiftRows and feeds the next-round state
// register. In the final round MixColumns is bypassed.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. ready_o is high only in IDLE and valid_o only in DONE, so the
// block holds one transaction at a time and has no combinational ready_i to
// ready_o path. The FSM state is kept in the enum register state_q.
module mixcol_addkey_serial #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    input  logic         last_round_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    // Only 1, 2 and 4 divide the four columns evenly.
    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mixcol_addkey_serial: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [1:0]     col_cnt_q;
    logic [127:0]   data_q;
    logic [127:0]   key_q;
    logic           last_q;
    logic [127:0]   result_q;
    logic [127:0]   result_d;
    logic           ready_q;
    logic           valid_q;
    logic [2:0]     cnt_next;

    // GF(2^8) multiply by 2 with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column; row 0 is in the top byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Counter value after this BUSY edge; bit 2 set means column 3 was written.
    assign cnt_next = {1'b0, col_cnt_q} + 3'(COLS_PER_CYCLE);

    // Next result: the current column group is recomputed, other columns kept.
    always_comb begin
        logic [1:0]  idx;
        logic [6:0]  base;
        logic [31:0] col;
        result_d = result_q;
        idx      = '0;
        base     = '0;
        col      = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx  = col_cnt_q + 2'(k);
            base = 7'd96 - {idx, 5'b00000};
            col  = data_q[base +: 32];
            result_d[base +: 32] = (last_q ? col : mix_col(col)) ^ key_q[base +: 32];
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            data_q    <= '0;
            key_q     <= '0;
            last_q    <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        data_q    <= data_i;
                        key_q     <= key_i;
                        last_q    <= last_round_i;
                        col_cnt_q <= '0;
                        state_q   <= BUSY;
                        ready_q   <= 1'b0;
                    end
                end
                BUSY: begin
                    result_q  <= result_d;
                    col_cnt_q <= cnt_next[1:0];
                    if (cnt_next[2]) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = result_q;

endmodule

// File: tb/tb_mixcol_addkey_serial.sv
// Self-checking bench for mixcol_addkey_serial: known AES vectors, a
// reference model for random vectors, backpressure, reset mid-operation
// and back-to-back acceptance.
module tb_mixcol_addkey_serial;

    localparam int COLS    = 1;
    localparam int LAT     = 4 / COLS;
    localparam int TIMEOUT = 50;

    // ---------------- clock / reset ----------------
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [127:0] data_i = '0;
    logic [127:0] key_i = '0;
    logic         last_round_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [127:0] data_o;

    always #5 clk_i = ~clk_i;

    mixcol_addkey_serial #(.COLS_PER_CYCLE(COLS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .key_i        (key_i),
        .last_round_i (last_round_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o)
    );

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_KEY = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Reference round back-end using the MixColumns matrix rows.
    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                           input logic last);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   b [4];
        logic [7:0]   m [4][4];
        m[0] = '{8'h02, 8'h03, 8'h01, 8'h01};
        m[1] = '{8'h01, 8'h02, 8'h03, 8'h01};
        m[2] = '{8'h01, 8'h01, 8'h02, 8'h03};
        m[3] = '{8'h03, 8'h01, 8'h01, 8'h02};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) a[row] = d[127 - 32*c - 8*row -: 8];
            for (int row = 0; row < 4; row++) begin
                if (last) b[row] = a[row];
                else b[row] = gmul(m[row][0], a[0]) ^ gmul(m[row][1], a[1]) ^
                              gmul(m[row][2], a[2]) ^ gmul(m[row][3], a[3]);
                r[127 - 32*c - 8*row -: 8] = b[row] ^ k[127 - 32*c - 8*row -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    // Waits (bounded) for ready_o, then presents one block for one edge.
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic last);
        int w;
        w = 0;
        while (!ready_o && w < TIMEOUT) begin
            @(posedge clk_i); #1;
            w++;
        end
        if (w == TIMEOUT) begin
            n_tests++; n_fail++;
            $display("FAIL send_ready_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, w);
        end
        valid_i      = 1'b1;
        data_i       = d;
        key_i        = k;
        last_round_i = last;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    // Counts edges until valid_o is seen; counts a timeout as a failure.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid_o && edges < TIMEOUT) begin
            @(posedge clk_i); #1;
            edges++;
        end
        if (!valid_o) begin
            n_tests++; n_fail++;
            $display("FAIL wait_valid_timeout: valid_o=0 after %0d edges, required 1", edges);
        end
    endtask

    // Pushes expectation, sends block, checks latency and popped result.
    task automatic run_one(input string name, input logic [127:0] d, input logic [127:0] k,
                           input logic last, input logic [127:0] exp);
        int edges;
        logic [127:0] e;
        exp_q.push_back(exp);
        send(d, k, last);
        wait_valid(edges);
        n_tests++;
        if (edges !== LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, edges, LAT);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (data_o !== e) begin
            n_fail++;
            $display("FAIL %s_data: got %h, required %h", name, data_o, e);
        end
        if (ready_i) begin
            @(posedge clk_i); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b, required 0", valid_o);
        end
        n_tests++;
        if (data_o !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got %h, required 0", data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_tests++;
        if (ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, required 1", ready_o);
        end
    endtask

    task automatic test_single_col();
        run_one("single_col", 128'hdb135345_01010101_c6c6c6c6_d4d4d4d5, 128'h0, 1'b0,
                128'h8e4da1bc_01010101_c6c6c6c6_d5d5d7d6);
    endtask

    task automatic test_fips();
        run_one("fips_round1", FIPS_IN, FIPS_KEY, 1'b0, FIPS_OUT);
    endtask

    task automatic test_final_round();
        run_one("final_key0", FIPS_IN, 128'h0, 1'b1, FIPS_IN);
        run_one("final_keyff", FIPS_IN, {128{1'b1}}, 1'b1, ~FIPS_IN);
    endtask

    task automatic test_random();
        logic [127:0] d, k;
        logic last;
        for (int i = 0; i < 6; i++) begin
            d = rand128();
            k = rand128();
            last = 1'($urandom_range(0, 1));
            run_one("random", d, k, last, model(d, k, last));
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] hold;
        hold = model(FIPS_IN, FIPS_KEY, 1'b0);
        ready_i = 1'b0;
        run_one("bp_first", FIPS_IN, FIPS_KEY, 1'b0, hold);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                valid_i = 1'b1;
                data_i  = rand128();
                key_i   = rand128();
            end
            if (i == 6) valid_i = 1'b0;
            @(posedge clk_i); #1;
            n_tests++;
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_o !== hold) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h, required valid=1 ready=0 data=%h",
                         i, valid_o, ready_o, data_o, hold);
            end
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b, required valid=0 ready=1", valid_o, ready_o);
        end
        @(posedge clk_i); #1;
        n_tests++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_no_capture: ready=%b, required 1 (no block captured)", ready_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        send(FIPS_IN, FIPS_KEY, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || data_o !== 128'h0) begin
            n_fail++;
            $display("FAIL rst_busy_clear: valid=%b data=%h, required valid=0 data=0", valid_o, data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_ready: ready=%b valid=%b, required ready=1 valid=0", ready_o, valid_o);
        end
        run_one("rst_busy_fresh", FIPS_IN, FIPS_KEY, 1'b0, FIPS_OUT);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d2, k2, e;
        int cyc, first_rise, second_rise, rises;
        logic prev_valid;
        d2 = rand128();
        k2 = rand128();
        exp_q.push_back(FIPS_OUT);
        exp_q.push_back(model(d2, k2, 1'b0));
        ready_i      = 1'b1;
        valid_i      = 1'b1;
        data_i       = FIPS_IN;
        key_i        = FIPS_KEY;
        last_round_i = 1'b0;
        @(posedge clk_i); #1;
        data_i = d2;
        key_i  = k2;
        cyc = 0; rises = 0; first_rise = 0; second_rise = 0; prev_valid = 1'b0;
        while (rises < 2 && cyc < 100) begin
            if (valid_o && !prev_valid) begin
                rises++;
                if (rises == 1) first_rise = cyc; else second_rise = cyc;
                e = exp_q.pop_front();
                n_tests++;
                if (data_o !== e) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: got %h, required %h", rises, data_o, e);
                end
            end
            prev_valid = valid_o;
            if (rises == 1 && cyc == first_rise + 2) valid_i = 1'b0;
            if (rises < 2) begin
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        valid_i = 1'b0;
        n_tests++;
        if (rises != 2) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results, required 2", rises);
        end else if (second_rise - first_rise != LAT + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d", second_rise - first_rise, LAT + 2);
        end
        @(posedge clk_i); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_col();
        test_fips();
        test_final_round();
        test_random();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
